llr_retry_controller: RTL and testbench
=======================================

# llr_retry_controller

Sequencing controller for the link-layer retry (LLR) datapath. It decides each cycle whether the retry buffer is written with a new TX flit or read for replay. It issues RETRY.Req, times out missing RETRY.Ack, and escalates repeated failures to PHY re-init and then link failure. It sits between the packer/unpacker and the retry buffer and drives the retry block's controller-side strobes.

## Interface
Parameters:
- PTR_W, 8, width of replay count (buffer depth 2^PTR_W)
- TMO_W, 13, width of timeout limit/timer
- CNT_W, 5, width of retry / re-init counters and thresholds

Ports:
- i_clk  in  1  sole clock, all state on rising edge
- i_rst  in  1  reset; one clock, reset asynchronous and active-high
- i_init_done  in  1  link-layer initialization complete
- i_pl_lnk_up  in  1  PHY link up
- i_flit_valid  in  1  new TX flit offered by packer
- i_tx_ready  in  1  TX slot available this cycle
- i_rx_crc_bad  in  1  pulse: received flit failed CRC
- i_rx_retry_ack  in  1  pulse: RETRY.Ack received
- i_replay_count  in  PTR_W  flits to replay, valid with i_rx_retry_ack
- i_timeout_max  in  TMO_W  ack timeout in cycles (0 treated as 1)
- i_retry_threshold  in  CNT_W  max RETRY.Req attempts before re-init
- i_reinit_threshold  in  CNT_W  max re-inits before link failure
- o_wr_en  out  1  write current TX flit into retry buffer
- o_rd_en  out  1  read next replay flit
- o_req_sent_flag  out  1  pulse: RETRY.Req sent
- o_inc_time_out_retry  out  1  pulse: ack timeout fired
- o_phy_reinit_req  out  1  level: request PHY re-init
- o_link_failure  out  1  sticky link failure
- o_num_retry  out  CNT_W  RETRY.Req attempts in current episode
- o_num_phy_reinit  out  CNT_W  re-inits since reset
- o_state  out  3  current FSM state encoding

## Operation
- States: IDLE, NORMAL, REQ, WAIT_ACK, REPLAY, REINIT, FAILED.
- IDLE: go to NORMAL when i_init_done & i_pl_lnk_up.
- NORMAL: o_wr_en = i_flit_valid & i_tx_ready & i_pl_lnk_up. i_rx_crc_bad, or a pending flag, goes to REQ.
- REQ: on first cycle with i_tx_ready, pulse o_req_sent_flag, increment o_num_retry, clear timer, go to WAIT_ACK.
- WAIT_ACK: timer increments every cycle.
  - i_rx_retry_ack clears o_num_retry and loads the replay counter with i_replay_count. Count 0 goes to NORMAL; otherwise go to REPLAY.
  - Timer reaching i_timeout_max pulses o_inc_time_out_retry. If o_num_retry >= i_retry_threshold, go to REINIT; otherwise go to REQ.
  - Ack and timeout in the same cycle: ack wins, no timeout pulse.
- REPLAY: o_rd_en = i_tx_ready & i_pl_lnk_up; each read decrements the counter. The read that takes the counter from 1 to 0 returns to NORMAL. o_wr_en is held 0.
- REINIT: o_phy_reinit_req = 1. On entry, increment o_num_phy_reinit and clear o_num_retry.
  - If the incremented value >= i_reinit_threshold, go to FAILED.
  - Otherwise wait for i_pl_lnk_up to fall and then rise, then go to REQ.
- FAILED: o_link_failure = 1; only i_rst leaves.
- i_rx_crc_bad in REQ/WAIT_ACK is ignored. In REPLAY it sets a pending flag, serviced on the cycle after NORMAL is reached.
- i_rx_retry_ack outside WAIT_ACK is ignored.
- Counters saturate at 2^CNT_W-1.
- Threshold 0 behaves as 1.

## Timing
- Reset values: every output 0, state IDLE, timer 0, pending flag 0.
- o_wr_en and o_rd_en are combinational from registered state and same-cycle inputs (zero latency to i_tx_ready).
- All other outputs are registered. Pulses are exactly one cycle wide, asserted the cycle after the causing event.
- Timeout fires exactly i_timeout_max cycles after WAIT_ACK entry.
- i_timeout_max changes take effect at the next WAIT_ACK entry; the limit is latched on entry.
- Replay count is latched at the ack; later changes to i_replay_count are ignored.
- Reset asserted mid-replay or mid-timeout immediately returns to IDLE with outputs 0.

## Structure
- Shared package llr_ctrl_pkg:
  - state enum llr_state_e, 3-bit
  - width constants PTR_W, TMO_W, CNT_W
- One sub-module, llr_ack_timer:
  - load/clear, count, compare to latched limit
  - outputs a one-cycle expire pulse
- FSM, replay counter and escalation counters live in the top.

## Test plan
- Reset, init: i_init_done=1, lnk_up=1, flit_valid=1 with tx_ready toggling 1/0 -> o_wr_en follows tx_ready; o_rd_en=0; o_state=NORMAL.
- CRC error, replay: i_rx_crc_bad pulse -> o_req_sent_flag one cycle later. Ack after 5 cycles with i_replay_count=3 -> exactly 3 o_rd_en cycles, then NORMAL with o_num_retry=0.
- Timeout escalation: i_timeout_max=10, i_retry_threshold=2, no ack -> o_inc_time_out_retry at 10 cycles after each WAIT_ACK entry; after 2nd timeout, REINIT with o_phy_reinit_req=1 and o_num_phy_reinit=1.
- Link failure: i_reinit_threshold=1, drive to REINIT -> FAILED with o_link_failure=1, held until i_rst.
- Simultaneous events: ack and timeout in the same cycle -> no timeout pulse, REPLAY entered. i_rx_crc_bad during REPLAY -> REQ taken the cycle after NORMAL.
- Async reset: i_rst mid-REPLAY, asserted off-edge -> all outputs 0 before the next clock edge.

Source files
------------

// File: rtl/llr_ctrl_pkg.sv
// Shared types and default widths for the link-layer retry controller.
package llr_ctrl_pkg;

  localparam int unsigned PTR_W = 8;
  localparam int unsigned TMO_W = 13;
  localparam int unsigned CNT_W = 5;

  typedef enum logic [2:0] {
    LlrIdle    = 3'd0,
    LlrNormal  = 3'd1,
    LlrReq     = 3'd2,
    LlrWaitAck = 3'd3,
    LlrReplay  = 3'd4,
    LlrReinit  = 3'd5,
    LlrFailed  = 3'd6
  } llr_state_e;

endpackage

// File: rtl/llr_retry_controller_if.sv
// Controller-side bundle between the LLR sequencer and packer/unpacker/retry buffer.
interface llr_retry_controller_if #(
  parameter int unsigned PTR_W = llr_ctrl_pkg::PTR_W,
  parameter int unsigned TMO_W = llr_ctrl_pkg::TMO_W,
  parameter int unsigned CNT_W = llr_ctrl_pkg::CNT_W
);
  logic             i_init_done;
  logic             i_pl_lnk_up;
  logic             i_flit_valid;
  logic             i_tx_ready;
  logic             i_rx_crc_bad;
  logic             i_rx_retry_ack;
  logic [PTR_W-1:0] i_replay_count;
  logic [TMO_W-1:0] i_timeout_max;
  logic [CNT_W-1:0] i_retry_threshold;
  logic [CNT_W-1:0] i_reinit_threshold;
  logic             o_wr_en;
  logic             o_rd_en;
  logic             o_req_sent_flag;
  logic             o_inc_time_out_retry;
  logic             o_phy_reinit_req;
  logic             o_link_failure;
  logic [CNT_W-1:0] o_num_retry;
  logic [CNT_W-1:0] o_num_phy_reinit;
  logic [2:0]       o_state;

  modport master (
    input  i_init_done, i_pl_lnk_up, i_flit_valid, i_tx_ready, i_rx_crc_bad, i_rx_retry_ack,
    input  i_replay_count, i_timeout_max, i_retry_threshold, i_reinit_threshold,
    output o_wr_en, o_rd_en, o_req_sent_flag, o_inc_time_out_retry, o_phy_reinit_req,
    output o_link_failure, o_num_retry, o_num_phy_reinit, o_state
  );

  modport slave (
    output i_init_done, i_pl_lnk_up, i_flit_valid, i_tx_ready, i_rx_crc_bad, i_rx_retry_ack,
    output i_replay_count, i_timeout_max, i_retry_threshold, i_reinit_threshold,
    input  o_wr_en, o_rd_en, o_req_sent_flag, o_inc_time_out_retry, o_phy_reinit_req,
    input  o_link_failure, o_num_retry, o_num_phy_reinit, o_state
  );
endinterface

// File: rtl/llr_ack_timer.sv
// RETRY.Ack timer: load clears the count and latches the limit; expire_o marks the last
// counting cycle so the owner reacts with a registered pulse exactly limit cycles after load.
module llr_ack_timer #(
  parameter int unsigned TMO_W = llr_ctrl_pkg::TMO_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             count_i,
  input  logic [TMO_W-1:0] limit_i,
  output logic             expire_o
);
  logic [TMO_W-1:0] cnt_q, cnt_d, lim_q, lim_d;

  assign expire_o = count_i && (cnt_q == lim_q - TMO_W'(1));

  always_comb begin
    cnt_d = cnt_q;
    lim_d = lim_q;
    if (load_i) begin
      cnt_d = '0;
      lim_d = (limit_i == '0) ? TMO_W'(1) : limit_i;
    end else if (count_i && !expire_o) begin
      cnt_d = cnt_q + TMO_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      lim_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      lim_q <= lim_d;
    end
  end
endmodule

// File: rtl/llr_retry_controller.sv
// LLR sequencer: chooses retry-buffer write vs replay read, issues RETRY.Req, times out
// missing acks and escalates to PHY re-init and finally sticky link failure.
module llr_retry_controller #(
  parameter int unsigned PTR_W = llr_ctrl_pkg::PTR_W,
  parameter int unsigned TMO_W = llr_ctrl_pkg::TMO_W,
  parameter int unsigned CNT_W = llr_ctrl_pkg::CNT_W
) (
  input logic                   i_clk,
  input logic                   i_rst,
  llr_retry_controller_if.master bus
);
  import llr_ctrl_pkg::*;

  localparam logic [2:0] StIdle    = LlrIdle;
  localparam logic [2:0] StNormal  = LlrNormal;
  localparam logic [2:0] StReq     = LlrReq;
  localparam logic [2:0] StWaitAck = LlrWaitAck;
  localparam logic [2:0] StReplay  = LlrReplay;
  localparam logic [2:0] StReinit  = LlrReinit;
  localparam logic [2:0] StFailed  = LlrFailed;
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [2:0]       state_q, state_d;
  logic [PTR_W-1:0] replay_q, replay_d;
  logic [CNT_W-1:0] num_retry_q, num_retry_d, num_reinit_q, num_reinit_d;
  logic             pending_q, pending_d, seen_down_q, seen_down_d;
  logic             req_q, req_d, tmo_q, tmo_d, reinit_q, fail_q;
  logic             tmr_load, tmr_expire, wr_en, rd_en;
  logic [CNT_W-1:0] retry_thr, reinit_thr;

  assign retry_thr  = (bus.i_retry_threshold == '0) ? CNT_W'(1) : bus.i_retry_threshold;
  assign reinit_thr = (bus.i_reinit_threshold == '0) ? CNT_W'(1) : bus.i_reinit_threshold;

  llr_ack_timer #(.TMO_W(TMO_W)) u_ack_timer (
    .clk_i    (i_clk),
    .rst_i    (i_rst),
    .load_i   (tmr_load),
    .count_i  (state_q == StWaitAck),
    .limit_i  (bus.i_timeout_max),
    .expire_o (tmr_expire)
  );

  always_comb begin
    state_d      = state_q;
    replay_d     = replay_q;
    num_retry_d  = num_retry_q;
    num_reinit_d = num_reinit_q;
    pending_d    = pending_q;
    seen_down_d  = seen_down_q;
    req_d        = 1'b0;
    tmo_d        = 1'b0;
    tmr_load     = 1'b0;
    wr_en        = 1'b0;
    rd_en        = 1'b0;
    case (state_q)
      StIdle: if (bus.i_init_done && bus.i_pl_lnk_up) state_d = StNormal;
      StNormal: begin
        wr_en = bus.i_flit_valid && bus.i_tx_ready && bus.i_pl_lnk_up;
        if (bus.i_rx_crc_bad || pending_q) begin
          state_d   = StReq;
          pending_d = 1'b0;
        end
      end
      StReq: if (bus.i_tx_ready) begin
        req_d    = 1'b1;
        tmr_load = 1'b1;
        state_d  = StWaitAck;
        if (num_retry_q != CntMax) num_retry_d = num_retry_q + CNT_W'(1);
      end
      StWaitAck: begin
        // Ack has priority over a timeout expiring in the same cycle.
        if (bus.i_rx_retry_ack) begin
          num_retry_d = '0;
          replay_d    = bus.i_replay_count;
          state_d     = (bus.i_replay_count == '0) ? StNormal : StReplay;
        end else if (tmr_expire) begin
          tmo_d = 1'b1;
          if (num_retry_q >= retry_thr) begin
            state_d     = StReinit;
            num_retry_d = '0;
            seen_down_d = 1'b0;
            if (num_reinit_q != CntMax) num_reinit_d = num_reinit_q + CNT_W'(1);
          end else begin
            state_d = StReq;
          end
        end
      end
      StReplay: begin
        rd_en = bus.i_tx_ready && bus.i_pl_lnk_up;
        if (bus.i_rx_crc_bad) pending_d = 1'b1;
        if (rd_en) begin
          replay_d = replay_q - PTR_W'(1);
          if (replay_q == PTR_W'(1)) state_d = StNormal;
        end
      end
      StReinit: begin
        if (num_reinit_q >= reinit_thr) state_d = StFailed;
        else if (!bus.i_pl_lnk_up)      seen_down_d = 1'b1;
        else if (seen_down_q)           state_d = StReq;
      end
      StFailed: ;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= StIdle;
      replay_q     <= '0;
      num_retry_q  <= '0;
      num_reinit_q <= '0;
      pending_q    <= 1'b0;
      seen_down_q  <= 1'b0;
      req_q        <= 1'b0;
      tmo_q        <= 1'b0;
      reinit_q     <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      replay_q     <= replay_d;
      num_retry_q  <= num_retry_d;
      num_reinit_q <= num_reinit_d;
      pending_q    <= pending_d;
      seen_down_q  <= seen_down_d;
      req_q        <= req_d;
      tmo_q        <= tmo_d;
      reinit_q     <= (state_d == StReinit);
      fail_q       <= (state_d == StFailed);
    end
  end

  assign bus.o_wr_en              = wr_en;
  assign bus.o_rd_en              = rd_en;
  assign bus.o_req_sent_flag      = req_q;
  assign bus.o_inc_time_out_retry = tmo_q;
  assign bus.o_phy_reinit_req     = reinit_q;
  assign bus.o_link_failure       = fail_q;
  assign bus.o_num_retry          = num_retry_q;
  assign bus.o_num_phy_reinit     = num_reinit_q;
  assign bus.o_state              = state_q;
endmodule

// File: tb/tb_llr_retry_controller.sv
// Self-checking bench: directed scenarios plus random traffic against an event-level model.
module tb_llr_retry_controller;
  import llr_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  llr_retry_controller_if bus ();
  llr_retry_controller dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: episode bookkeeping in plain integers.
  llr_state_e m_state;
  int m_num_retry, m_num_reinit, m_limit, m_left, m_entry;
  bit m_pending, m_seen_down, m_req_p, m_tmo_p;

  logic [20:0] act;
  assign act = {bus.o_wr_en, bus.o_rd_en, bus.o_req_sent_flag, bus.o_inc_time_out_retry,
                bus.o_phy_reinit_req, bus.o_link_failure, bus.o_num_retry,
                bus.o_num_phy_reinit, bus.o_state};

  function automatic logic [20:0] exp_vec();
    logic wr, rd;
    wr = (m_state == LlrNormal) && bus.i_flit_valid && bus.i_tx_ready && bus.i_pl_lnk_up;
    rd = (m_state == LlrReplay) && bus.i_tx_ready && bus.i_pl_lnk_up;
    return {wr, rd, m_req_p, m_tmo_p, m_state == LlrReinit, m_state == LlrFailed,
            5'(m_num_retry), 5'(m_num_reinit), m_state};
  endfunction

  task automatic model_reset();
    m_state = LlrIdle;
    m_num_retry = 0; m_num_reinit = 0; m_limit = 1; m_left = 0; m_entry = 0;
    m_pending = 0; m_seen_down = 0; m_req_p = 0; m_tmo_p = 0;
  endtask

  task automatic model_step();
    llr_state_e ns;
    int thr, rthr, tmo;
    ns   = m_state;
    thr  = (bus.i_retry_threshold == 0) ? 1 : int'(bus.i_retry_threshold);
    rthr = (bus.i_reinit_threshold == 0) ? 1 : int'(bus.i_reinit_threshold);
    tmo  = (bus.i_timeout_max == 0) ? 1 : int'(bus.i_timeout_max);
    m_req_p = 0;
    m_tmo_p = 0;
    case (m_state)
      LlrIdle: if (bus.i_init_done && bus.i_pl_lnk_up) ns = LlrNormal;
      LlrNormal: if (bus.i_rx_crc_bad || m_pending) begin ns = LlrReq; m_pending = 0; end
      LlrReq: if (bus.i_tx_ready) begin
        m_req_p = 1;
        m_num_retry = (m_num_retry < 31) ? m_num_retry + 1 : 31;
        m_limit = tmo;
        m_entry = cyc + 1;
        ns = LlrWaitAck;
      end
      LlrWaitAck: begin
        if (bus.i_rx_retry_ack) begin
          m_num_retry = 0;
          m_left = int'(bus.i_replay_count);
          ns = (m_left == 0) ? LlrNormal : LlrReplay;
        end else if (cyc - m_entry + 1 == m_limit) begin
          m_tmo_p = 1;
          if (m_num_retry >= thr) begin
            ns = LlrReinit;
            m_num_retry = 0;
            m_seen_down = 0;
            m_num_reinit = (m_num_reinit < 31) ? m_num_reinit + 1 : 31;
          end else ns = LlrReq;
        end
      end
      LlrReplay: begin
        if (bus.i_rx_crc_bad) m_pending = 1;
        if (bus.i_tx_ready && bus.i_pl_lnk_up) begin
          m_left--;
          if (m_left == 0) ns = LlrNormal;
        end
      end
      LlrReinit: begin
        if (m_num_reinit >= rthr) ns = LlrFailed;
        else if (!bus.i_pl_lnk_up) m_seen_down = 1;
        else if (m_seen_down) ns = LlrReq;
      end
      default: ;
    endcase
    m_state = ns;
  endtask

  task automatic adv();
    if (rst) model_reset();
    else model_step();
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    #1;
    n_checks++;
    if (act !== 21'd0) begin
      n_fail++; $display("FAIL reset act=%h exp=0", act);
    end
    adv();
    rst = 1'b0;
  endtask

  task automatic test_init_write();
    bus.i_init_done = 1; bus.i_pl_lnk_up = 1; bus.i_flit_valid = 1; bus.i_tx_ready = 0;
    #1; adv();
    for (int i = 0; i < 6; i++) begin
      bus.i_tx_ready = i[0];
      #1;
      n_checks++;
      if (bus.o_state !== LlrNormal || bus.o_wr_en !== bus.i_tx_ready || bus.o_rd_en !== 1'b0) begin
        n_fail++;
        $display("FAIL init_write st=%0d wr=%b rd=%b exp st=1 wr=%b rd=0",
                 bus.o_state, bus.o_wr_en, bus.o_rd_en, bus.i_tx_ready);
      end
      n_checks++;
      if (act !== exp_vec()) begin
        n_fail++; $display("FAIL init_vec cyc=%0d act=%h exp=%h", cyc, act, exp_vec());
      end
      adv();
    end
  endtask

  task automatic test_crc_replay();
    int rd_cnt, reached;
    bus.i_tx_ready = 1; bus.i_rx_crc_bad = 1;
    #1; adv();
    bus.i_rx_crc_bad = 0;
    #1; adv();
    #1;
    n_checks++;
    if (bus.o_req_sent_flag !== 1'b1 || bus.o_state !== LlrWaitAck) begin
      n_fail++;
      $display("FAIL req_flag flag=%b st=%0d exp flag=1 st=3", bus.o_req_sent_flag, bus.o_state);
    end
    adv();
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if (act !== exp_vec()) begin
        n_fail++; $display("FAIL wait_vec cyc=%0d act=%h exp=%h", cyc, act, exp_vec());
      end
      adv();
    end
    bus.i_rx_retry_ack = 1; bus.i_replay_count = 8'd3;
    #1; adv();
    bus.i_rx_retry_ack = 0; bus.i_replay_count = 8'd7;
    rd_cnt = 0; reached = 0;
    for (int i = 0; i < 20; i++) begin
      bus.i_tx_ready = (i != 1);
      #1;
      n_checks++;
      if (act !== exp_vec()) begin
        n_fail++; $display("FAIL replay_vec cyc=%0d act=%h exp=%h", cyc, act, exp_vec());
      end
      if (bus.o_state === LlrNormal) begin reached = 1; break; end
      if (bus.o_rd_en === 1'b1) rd_cnt++;
      adv();
    end
    n_checks++;
    if (reached != 1 || rd_cnt != 3 || bus.o_num_retry !== 5'd0) begin
      n_fail++;
      $display("FAIL replay_count reached=%0d reads=%0d retry=%0d exp 1/3/0",
               reached, rd_cnt, bus.o_num_retry);
    end
    bus.i_tx_ready = 1;
    adv();
  endtask

  task automatic test_timeout_escalation();
    int entry, n_tmo;
    logic [2:0] prev;
    bus.i_timeout_max = 13'd10; bus.i_retry_threshold = 5'd2; bus.i_reinit_threshold = 5'd3;
    bus.i_rx_crc_bad = 1;
    #1; adv();
    bus.i_rx_crc_bad = 0;
    entry = 0; n_tmo = 0; prev = 3'd0;
    for (int i = 0; i < 100; i++) begin
      #1;
      n_checks++;
      if (act !== exp_vec()) begin
        n_fail++; $display("FAIL tmo_vec cyc=%0d act=%h exp=%h", cyc, act, exp_vec());
      end
      if (bus.o_state === LlrWaitAck && prev !== LlrWaitAck) begin
        entry = cyc;
        if (n_tmo == 0) bus.i_timeout_max = 13'd25;
      end
      if (bus.o_inc_time_out_retry === 1'b1) begin
        n_tmo++;
        bus.i_timeout_max = 13'd10;
        n_checks++;
        if (cyc - entry != 10) begin
          n_fail++; $display("FAIL tmo_delay got=%0d exp=10", cyc - entry);
        end
      end
      if (bus.o_state === LlrReinit) break;
      prev = bus.o_state;
      adv();
    end
    n_checks++;
    if (n_tmo != 2 || bus.o_phy_reinit_req !== 1'b1 || bus.o_num_phy_reinit !== 5'd1) begin
      n_fail++;
      $display("FAIL escalate tmo=%0d reinit_req=%b num_reinit=%0d exp 2/1/1",
               n_tmo, bus.o_phy_reinit_req, bus.o_num_phy_reinit);
    end
    for (int i = 0; i < 12; i++) begin
      bus.i_pl_lnk_up = !(i == 1 || i == 2);
      #1;
      n_checks++;
      if (act !== exp_vec()) begin
        n_fail++; $display("FAIL reinit_vec cyc=%0d act=%h exp=%h", cyc, act, exp_vec());
      end
      if (bus.o_state === LlrReq) break;
      adv();
    end
    n_checks++;
    if (bus.o_state !== LlrReq || bus.o_num_retry !== 5'd0) begin
      n_fail++;
      $display("FAIL reinit_exit st=%0d retry=%0d exp st=2 retry=0", bus.o_state, bus.o_num_retry);
    end
  endtask

  task automatic test_link_failure();
    bus.i_reinit_threshold = 5'd1; bus.i_retry_threshold = 5'd1; bus.i_timeout_max = 13'd2;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (bus.o_state === LlrFailed) break;
      adv();
    end
    for (int i = 0; i < 20; i++) begin
      bus.i_rx_retry_ack = 1'($urandom); bus.i_rx_crc_bad = 1'($urandom);
      bus.i_pl_lnk_up = 1'($urandom);
      #1;
      n_checks++;
      if (bus.o_link_failure !== 1'b1 || bus.o_state !== LlrFailed || act !== exp_vec()) begin
        n_fail++;
        $display("FAIL link_failure fail=%b st=%0d act=%h exp fail=1 st=6 vec=%h",
                 bus.o_link_failure, bus.o_state, act, exp_vec());
      end
      adv();
    end
    bus.i_rx_retry_ack = 0; bus.i_rx_crc_bad = 0; bus.i_pl_lnk_up = 1;
    rst = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (bus.o_link_failure !== 1'b0 || bus.o_state !== LlrIdle) begin
      n_fail++;
      $display("FAIL fail_reset fail=%b st=%0d exp 0/0", bus.o_link_failure, bus.o_state);
    end
    adv();
    rst = 1'b0;
  endtask

  task automatic test_simultaneous();
    int rd_cnt, got_req;
    logic [2:0] prev;
    bus.i_timeout_max = 13'd3; bus.i_retry_threshold = 5'd4; bus.i_reinit_threshold = 5'd4;
    bus.i_tx_ready = 1;
    #1; adv();
    bus.i_rx_crc_bad = 1;
    #1; adv();
    bus.i_rx_crc_bad = 0;
    #1; adv();
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++;
      if (act !== exp_vec()) begin
        n_fail++; $display("FAIL sim_vec cyc=%0d act=%h exp=%h", cyc, act, exp_vec());
      end
      adv();
    end
    bus.i_rx_retry_ack = 1; bus.i_replay_count = 8'd2;
    #1; adv();
    bus.i_rx_retry_ack = 0;
    #1;
    n_checks++;
    if (bus.o_inc_time_out_retry !== 1'b0 || bus.o_state !== LlrReplay) begin
      n_fail++;
      $display("FAIL ack_wins tmo=%b st=%0d exp tmo=0 st=4", bus.o_inc_time_out_retry, bus.o_state);
    end
    rd_cnt = 0; got_req = 0; prev = 3'd0;
    for (int i = 0; i < 20; i++) begin
      bus.i_rx_crc_bad = (i == 0);
      #1;
      n_checks++;
      if (act !== exp_vec()) begin
        n_fail++; $display("FAIL pend_vec cyc=%0d act=%h exp=%h", cyc, act, exp_vec());
      end
      if (bus.o_state === LlrReq) begin got_req = 1; break; end
      if (bus.o_rd_en === 1'b1) rd_cnt++;
      prev = bus.o_state;
      adv();
    end
    n_checks++;
    if (got_req != 1 || prev !== LlrNormal || rd_cnt != 2) begin
      n_fail++;
      $display("FAIL pending got_req=%0d prev=%0d reads=%0d exp 1/1/2", got_req, prev, rd_cnt);
    end
  endtask

  task automatic test_async_reset();
    bus.i_tx_ready = 1; bus.i_flit_valid = 1;
    #1; adv();
    bus.i_rx_retry_ack = 1; bus.i_replay_count = 8'd5;
    #1; adv();
    bus.i_rx_retry_ack = 0;
    #1;
    n_checks++;
    if (bus.o_state !== LlrReplay || bus.o_rd_en !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset st=%0d rd=%b exp st=4 rd=1", bus.o_state, bus.o_rd_en);
    end
    adv();
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (act !== 21'd0) begin
      n_fail++; $display("FAIL async_reset act=%h exp=0", act);
    end
    adv();
    rst = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      bus.i_init_done    = ($urandom_range(0, 19) != 0);
      bus.i_pl_lnk_up    = ($urandom_range(0, 15) != 0);
      bus.i_flit_valid   = 1'($urandom);
      bus.i_tx_ready     = ($urandom_range(0, 3) != 0);
      bus.i_rx_crc_bad   = ($urandom_range(0, 9) == 0);
      bus.i_rx_retry_ack = ($urandom_range(0, 5) == 0);
      bus.i_replay_count = 8'($urandom_range(0, 4));
      if ($urandom_range(0, 7) == 0) bus.i_timeout_max = 13'($urandom_range(0, 6));
      if ($urandom_range(0, 31) == 0) bus.i_retry_threshold = 5'($urandom_range(0, 3));
      if ($urandom_range(0, 31) == 0) bus.i_reinit_threshold = 5'($urandom_range(0, 3));
      rst = ($urandom_range(0, 149) == 0);
      if (rst) model_reset();
      #1;
      n_checks++;
      if (act !== exp_vec()) begin
        n_fail++; $display("FAIL random cyc=%0d act=%h exp=%h", cyc, act, exp_vec());
      end
      adv();
    end
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_init_done = 0; bus.i_pl_lnk_up = 0; bus.i_flit_valid = 0; bus.i_tx_ready = 0;
    bus.i_rx_crc_bad = 0; bus.i_rx_retry_ack = 0; bus.i_replay_count = '0;
    bus.i_timeout_max = 13'd50; bus.i_retry_threshold = 5'd3; bus.i_reinit_threshold = 5'd3;
    test_reset();
    test_init_write();
    test_crc_replay();
    test_timeout_escalation();
    test_link_failure();
    test_simultaneous();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
